// File: rtl/aes_wddl_pkg.sv
// Shared types and constants for the WDDL AES round controller: state encoding,
// round counts per key size and the registered control-output bundle.
package aes_wddl_pkg;

    localparam int AES_NR_128 = 10;
    localparam int AES_NR_192 = 12;
    localparam int AES_NR_256 = 14;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LD_PRE,
        ST_LD_EVAL,
        ST_RND_PRE,
        ST_RND_EVAL,
        ST_DONE
    } ctrl_state_t;

    typedef struct packed {
        logic busy;
        logic pre;
        logic ld_r;
        logic sa_en;
        logic kld;
        logic kstep;
        logic last;
        logic done;
    } ctrl_out_t;

    // Smallest counter width that can hold 0..nr without wrapping.
    function automatic int round_width(input int nr);
        return $clog2(nr + 1);
    endfunction

    function automatic ctrl_out_t decode_state(input ctrl_state_t s);
        ctrl_out_t o;
        o       = '0;
        o.busy  = (s != ST_IDLE);
        o.pre   = (s == ST_LD_PRE) || (s == ST_RND_PRE);
        o.kld   = (s == ST_LD_PRE);
        o.kstep = (s == ST_RND_PRE);
        o.ld_r  = (s == ST_LD_EVAL);
        o.sa_en = (s == ST_LD_EVAL) || (s == ST_RND_EVAL);
        o.done  = (s == ST_DONE);
        return o;
    endfunction

endpackage

// File: rtl/aes_wddl_round_ctrl_if.sv
// Host/datapath control bundle of the round controller. The master side issues
// start; the slave side (the controller) drives the phase and load controls.
interface aes_wddl_round_ctrl_if #(
    parameter int RW = 4
);
    logic          start;
    logic          busy;
    logic          pre;
    logic          ld_r;
    logic          sa_en;
    logic          kld;
    logic          kstep;
    logic [RW-1:0] round;
    logic          last;
    logic          done;

    modport master (
        output start,
        input  busy, pre, ld_r, sa_en, kld, kstep, round, last, done
    );

    modport slave (
        input  start,
        output busy, pre, ld_r, sa_en, kld, kstep, round, last, done
    );
endinterface

// File: rtl/aes_wddl_round_ctrl.sv
// Precharge/evaluate sequencer for the WDDL AES datapath. Every output is a flop
// decoded from the next state so the dual-rail logic sees glitch-free controls.
module aes_wddl_round_ctrl
    import aes_wddl_pkg::*;
#(
    parameter int NR = AES_NR_128,
    parameter int RW = round_width(NR)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_wddl_round_ctrl_if.slave bus
);

    localparam logic [RW-1:0] NR_L  = RW'(NR);
    localparam logic [RW-1:0] ONE_L = RW'(1);

    ctrl_state_t   state_q, state_d;
    logic [RW-1:0] round_q, round_d;
    ctrl_out_t     out_q, out_d;

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_LD_PRE;
                    round_d = '0;
                end
            end
            ST_LD_PRE:  state_d = ST_LD_EVAL;
            ST_LD_EVAL: begin
                state_d = ST_RND_PRE;
                round_d = ONE_L;
            end
            ST_RND_PRE: state_d = ST_RND_EVAL;
            ST_RND_EVAL: begin
                // >= rather than == so a corrupted count can never wrap past NR.
                if (round_q >= NR_L) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RND_PRE;
                    round_d = round_q + ONE_L;
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    state_d = ST_LD_PRE;
                    round_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                round_d = '0;
            end
        endcase

        out_d      = decode_state(state_d);
        out_d.last = (round_d == NR_L);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            round_q <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            out_q   <= out_d;
        end
    end

    assign bus.busy  = out_q.busy;
    assign bus.pre   = out_q.pre;
    assign bus.ld_r  = out_q.ld_r;
    assign bus.sa_en = out_q.sa_en;
    assign bus.kld   = out_q.kld;
    assign bus.kstep = out_q.kstep;
    assign bus.last  = out_q.last;
    assign bus.done  = out_q.done;
    assign bus.round = round_q;

    // WDDL needs a precharge between evaluates; these guard that property.
    a_pre_eval_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(out_q.pre && out_q.sa_en));
    a_ld_implies_en: assert property (@(posedge clk) disable iff (!rst_n)
        !(out_q.ld_r && !out_q.sa_en));
    a_key_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(out_q.kld && out_q.kstep));
    a_no_adjacent_eval: assert property (@(posedge clk) disable iff (!rst_n)
        out_q.sa_en |=> !out_q.sa_en);

endmodule

// File: tb/tb_aes_wddl_round_ctrl.sv
// Randomised self-checking bench for aes_wddl_round_ctrl with NR=10 and NR=14
// instances, compared cycle by cycle against a schedule-level reference model.
module tb_aes_wddl_round_ctrl;

    typedef struct packed {
        logic       busy;
        logic       pre;
        logic       ld_r;
        logic       sa_en;
        logic       kld;
        logic       kstep;
        logic       last;
        logic       done;
        logic [3:0] round;
    } obs_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   passed;

    // Model state: cycles since the accepted start (0 = idle) and the idle round value.
    int mk[2];
    int mheld[2];

    aes_wddl_round_ctrl_if #(.RW(4)) bus10 ();
    aes_wddl_round_ctrl_if #(.RW(4)) bus14 ();

    aes_wddl_round_ctrl #(.NR(10), .RW(4)) dut10 (.clk(clk), .rst_n(rst_n), .bus(bus10.slave));
    aes_wddl_round_ctrl #(.NR(14), .RW(4)) dut14 (.clk(clk), .rst_n(rst_n), .bus(bus14.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nr_of(input int sel);
        return (sel == 0) ? 10 : 14;
    endfunction

    function automatic obs_t sample(input int sel);
        obs_t o;
        if (sel == 0) begin
            o.busy = bus10.busy; o.pre = bus10.pre; o.ld_r = bus10.ld_r; o.sa_en = bus10.sa_en;
            o.kld = bus10.kld; o.kstep = bus10.kstep; o.last = bus10.last; o.done = bus10.done;
            o.round = bus10.round;
        end else begin
            o.busy = bus14.busy; o.pre = bus14.pre; o.ld_r = bus14.ld_r; o.sa_en = bus14.sa_en;
            o.kld = bus14.kld; o.kstep = bus14.kstep; o.last = bus14.last; o.done = bus14.done;
            o.round = bus14.round;
        end
        return o;
    endfunction

    // Cycle k of a run: 1 load-precharge, 2 whitening evaluate, 2r+1/2r+2 round r, 2NR+3 done.
    function automatic obs_t model_out(input int sel);
        obs_t o;
        int   k;
        int   nr;
        int   r;
        o  = '0;
        k  = mk[sel];
        nr = nr_of(sel);
        if (k == 0) begin
            o.round = 4'(mheld[sel]);
            o.last  = (mheld[sel] == nr);
        end else begin
            o.busy = 1'b1;
            if (k == 2 * nr + 3) begin
                o.done = 1'b1;
                r      = nr;
            end else if (k <= 2) begin
                r       = 0;
                o.pre   = (k == 1);
                o.kld   = (k == 1);
                o.ld_r  = (k == 2);
                o.sa_en = (k == 2);
            end else begin
                r       = (k - 1) / 2;
                o.pre   = (k % 2 == 1);
                o.kstep = (k % 2 == 1);
                o.sa_en = (k % 2 == 0);
            end
            o.round = 4'(r);
            o.last  = (r == nr);
        end
        return o;
    endfunction

    function automatic void model_step(input int sel, input logic s);
        int fin;
        fin = 2 * nr_of(sel) + 3;
        if (mk[sel] == 0 || mk[sel] == fin) begin
            if (mk[sel] == fin) mheld[sel] = nr_of(sel);
            mk[sel] = s ? 1 : 0;
        end else begin
            mk[sel] = mk[sel] + 1;
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            mk[i]    = 0;
            mheld[i] = 0;
        end
    endfunction

    task automatic tick(input logic s10, input logic s14);
        bus10.start = s10;
        bus14.start = s14;
        @(posedge clk);
        if (rst_n) begin
            model_step(0, s10);
            model_step(1, s14);
        end else begin
            model_reset();
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (sample(i) !== obs_t'(0))
                $display("[TB] FAIL reset_state dut%0d got=%h exp=%h", i, sample(i), obs_t'(0));
            else passed++;
        end
        rst_n = 1'b1;
        tick(1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (sample(i) !== model_out(i))
                $display("[TB] FAIL reset_release dut%0d got=%h exp=%h", i, sample(i), model_out(i));
            else passed++;
        end
    endtask

    task automatic test_single_run();
        int done_cyc;
        int ld_cnt;
        done_cyc = -1;
        ld_cnt   = 0;
        for (int k = 1; k <= 26; k++) begin
            tick(k == 1, 1'b0);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (sample(i) !== model_out(i))
                    $display("[TB] FAIL single_run dut%0d cyc=%0d got=%h exp=%h", i, k, sample(i), model_out(i));
                else passed++;
            end
            if (bus10.done && done_cyc < 0) done_cyc = k;
            if (bus10.ld_r) ld_cnt++;
        end
        checks++;
        if (done_cyc !== 23) $display("[TB] FAIL single_run_done_cycle got=%0d exp=23", done_cyc);
        else passed++;
        checks++;
        if (ld_cnt !== 1) $display("[TB] FAIL single_run_ld_r_count got=%0d exp=1", ld_cnt);
        else passed++;
    endtask

    task automatic test_ignored_start();
        int dones;
        int done_cyc;
        dones    = 0;
        done_cyc = -1;
        for (int k = 1; k <= 28; k++) begin
            tick(k == 1 || k == 6 || k == 16, 1'b0);
            checks++;
            if (sample(0) !== model_out(0))
                $display("[TB] FAIL ignored_start cyc=%0d got=%h exp=%h", k, sample(0), model_out(0));
            else passed++;
            if (bus10.done) begin
                dones++;
                done_cyc = k;
            end
        end
        checks++;
        if (dones !== 1 || done_cyc !== 23)
            $display("[TB] FAIL ignored_start_done got=%0d@%0d exp=1@23", dones, done_cyc);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int done_q[$];
        int kld_q[$];
        for (int k = 1; k <= 110; k++) begin
            tick(k <= 60, k <= 60);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (sample(i) !== model_out(i))
                    $display("[TB] FAIL back_to_back dut%0d cyc=%0d got=%h exp=%h", i, k, sample(i), model_out(i));
                else passed++;
            end
            if (bus10.done) done_q.push_back(k);
            if (bus10.kld) kld_q.push_back(k);
        end
        checks++;
        if (done_q.size() < 2 || done_q[0] !== 23 || done_q[1] !== 46)
            $display("[TB] FAIL back_to_back_done n=%0d first=%0d second=%0d exp=23,46", done_q.size(),
                     (done_q.size() > 0) ? done_q[0] : -1, (done_q.size() > 1) ? done_q[1] : -1);
        else passed++;
        checks++;
        if (kld_q.size() < 3 || kld_q[1] !== 24 || kld_q[2] !== 47)
            $display("[TB] FAIL back_to_back_ld_pre n=%0d exp=24,47", kld_q.size());
        else passed++;
    endtask

    task automatic test_reset_mid_run();
        int dones;
        int done_cyc;
        for (int k = 1; k <= 9; k++) tick(k == 1, k == 1);
        bus10.start = 1'b0;
        bus14.start = 1'b0;
        @(posedge clk);
        model_step(0, 1'b0);
        model_step(1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (sample(i) !== obs_t'(0))
                $display("[TB] FAIL mid_run_reset dut%0d got=%h exp=%h", i, sample(i), obs_t'(0));
            else passed++;
        end
        @(negedge clk);
        tick(1'b0, 1'b0);
        rst_n = 1'b1;
        dones = 0;
        for (int k = 1; k <= 30; k++) begin
            tick(1'b0, 1'b0);
            checks++;
            if (sample(0) !== model_out(0))
                $display("[TB] FAIL after_reset_idle cyc=%0d got=%h exp=%h", k, sample(0), model_out(0));
            else passed++;
            if (bus10.done || bus14.done) dones++;
        end
        checks++;
        if (dones !== 0) $display("[TB] FAIL after_reset_no_done got=%0d exp=0", dones);
        else passed++;
        done_cyc = -1;
        for (int k = 1; k <= 25; k++) begin
            tick(k == 1, 1'b0);
            checks++;
            if (sample(0) !== model_out(0))
                $display("[TB] FAIL restart_run cyc=%0d got=%h exp=%h", k, sample(0), model_out(0));
            else passed++;
            if (bus10.done && done_cyc < 0) done_cyc = k;
        end
        checks++;
        if (done_cyc !== 23) $display("[TB] FAIL restart_done_cycle got=%0d exp=23", done_cyc);
        else passed++;
    endtask

    task automatic test_nr14();
        int kld_cnt;
        int kstep_cnt;
        int done_cyc;
        kld_cnt   = 0;
        kstep_cnt = 0;
        done_cyc  = -1;
        for (int k = 1; k <= 34; k++) begin
            tick(1'b0, k == 1);
            checks++;
            if (sample(1) !== model_out(1))
                $display("[TB] FAIL nr14_run cyc=%0d got=%h exp=%h", k, sample(1), model_out(1));
            else passed++;
            if (bus14.kld) kld_cnt++;
            if (bus14.kstep) kstep_cnt++;
            if (bus14.done && done_cyc < 0) done_cyc = k;
        end
        checks++;
        if (done_cyc !== 31) $display("[TB] FAIL nr14_done_cycle got=%0d exp=31", done_cyc);
        else passed++;
        checks++;
        if (kld_cnt !== 1 || kstep_cnt !== 14)
            $display("[TB] FAIL nr14_key_counts got=kld%0d/kstep%0d exp=kld1/kstep14", kld_cnt, kstep_cnt);
        else passed++;
    endtask

    task automatic test_random();
        logic prev_en[2];
        obs_t o;
        prev_en[0] = 1'b0;
        prev_en[1] = 1'b0;
        for (int k = 1; k <= 600; k++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            for (int i = 0; i < 2; i++) begin
                o = sample(i);
                checks++;
                if (o !== model_out(i))
                    $display("[TB] FAIL random_model dut%0d cyc=%0d got=%h exp=%h", i, k, o, model_out(i));
                else passed++;
                checks++;
                if ((o.pre && o.sa_en) || (o.ld_r && !o.sa_en) || (o.kld && o.kstep) || (o.sa_en && prev_en[i]))
                    $display("[TB] FAIL random_invariant dut%0d cyc=%0d got=%h prev_sa_en=%0b", i, k, o, prev_en[i]);
                else passed++;
                prev_en[i] = o.sa_en;
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        checks      = 0;
        passed      = 0;
        rst_n       = 1'b1;
        bus10.start = 1'b0;
        bus14.start = 1'b0;
        model_reset();
        #3;
        test_reset();
        test_single_run();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_run();
        test_nr14();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
